in_port_buffer: RTL and testbench
=================================

Name: in_port_buffer

Overview:
- Parametrised successor to the 4-bit tristate input register on the microprocessor's internal bus.
- Accepts external words through a valid/ready handshake and buffers them in a DEPTH-entry FIFO.
- Drives the head word onto the internal bus IB through tristate outputs while EnableIn is high.
- Adds occupancy status plus sticky overflow/underflow flags for the control unit.

Parameters:
- WIDTH, 4, bit width of DataIn and IB.
- DEPTH, 4, FIFO entries; power of two, 2..16.
- CW, $clog2(DEPTH+1), width of Count (derived, not overridden).

Ports:
- CLK  input  1  single clock; all state updates on the rising edge.
- ResetN  input  1  reset, synchronous, active-low.
- DataIn  input  WIDTH  external data word.
- DataInValid  input  1  external word present.
- DataInReady  output  1  buffer can accept a word.
- EnableIn  input  1  drive IB from the head entry; when low, IB is high-Z.
- PopIn  input  1  consume the head entry at this edge; acts only while EnableIn=1.
- IB  output (tristate)  WIDTH  internal bus.
- Count  output  CW  number of entries held.
- Empty  output  1  Count==0.
- Full  output  1  Count==DEPTH.
- Overflow  output  1  sticky: a write was attempted while full.
- Underflow  output  1  sticky: a pop was attempted while empty.
- ClearFlags  input  1  clears Overflow and Underflow.

Behaviour:
- Reset (ResetN=0 at an edge):
  - write pointer, read pointer and Count go to 0; Overflow=0, Underflow=0.
  - DataInReady=0 for as long as ResetN=0.
  - IB still follows the EnableIn rule; Empty shows 1 after the first reset edge.
  - Reset mid-transfer discards all entries; no push or pop occurs at that edge.
- DataInReady = ResetN & !Full. This is combinational from registered state; ready does not depend on PopIn.
- Push: at an edge where DataInValid & DataInReady, store DataIn at the write pointer, increment the pointer modulo DEPTH, and increment Count.
- Pop: at an edge where EnableIn & PopIn & !Empty, increment the read pointer modulo DEPTH and decrement Count. The next head appears on IB in the following cycle.
- Simultaneous push and pop:
  - Both take effect and Count is unchanged.
  - When Full, only the pop occurs (ready=0). Count becomes DEPTH-1 and ready rises next cycle.
  - When Empty, only the push occurs and Underflow sets. A just-written word is never bypassed onto IB in the same cycle.
- IB (combinational):
  - EnableIn=1 & !Empty: IB = mem[read pointer].
  - EnableIn=1 & Empty: IB = all zeros.
  - EnableIn=0: IB = high-Z on every bit.
- Overflow sets at an edge with DataInValid & Full & ResetN. The word is dropped and there is no state change.
- Underflow sets at an edge with EnableIn & PopIn & Empty.
- ClearFlags at an edge clears both flags. If a set condition occurs at the same edge, set wins.
- Latency: an accepted word is visible on IB (with EnableIn=1) one cycle after its push edge when the FIFO was empty.
- Pointers are log2(DEPTH) bits and wrap naturally. Count saturates by construction: there is no push when full and no pop when empty.
- Data order is strictly FIFO. Entry contents are not reset, and stale data is never observable because IB drives zeros when Empty.

Decomposition:
- Package in_port_pkg holds:
  - default WIDTH/DEPTH constants;
  - a function for pointer width;
  - a constant for the IB idle value (all-Z) and the empty-read value (all-0).
- One sub-module: in_port_ram, a DEPTH×WIDTH register array.
  - synchronous write port (we, waddr, wdata) and asynchronous read port (raddr, rdata);
  - no reset on the array.
- Pointer/count/flag control stays in in_port_buffer.

Test Plan:
- Reset then idle, EnableIn=0 -> IB=4'bzzzz, Empty=1, Count=0, DataInReady=1, both flags 0.
- Push 4'h3, 4'hA, 4'h5 on consecutive cycles, then EnableIn=1 and PopIn=1 for 3 cycles -> IB shows 3, A, 5 in order; Count goes 3,2,1,0; Empty=1 at the end.
- Push 5 words (1..5) with DEPTH=4, no pops -> Full=1 after the 4th; 5th dropped, Overflow=1, DataInReady=0; then drain -> 1,2,3,4.
- Full FIFO, DataInValid=1 and pop on the same edge -> only the pop happens, Count=3; the next cycle the pending word is accepted, Count=4.
- Empty FIFO, EnableIn=1, PopIn=1 -> IB=4'b0000, Underflow=1; ClearFlags pulse -> Underflow=0; repeat with ClearFlags and pop on the same edge -> Underflow stays 1.
- ResetN=0 for one edge with Count=2 mid-drain -> Count=0, Empty=1, flags 0; rerun with WIDTH=8, DEPTH=16 and a wrap-around test of 20 push/pop pairs -> data order preserved.

Source files
------------

// File: rtl/in_port_pkg.sv
// Shared constants for the internal-bus input port buffer.
//   IN_PORT_WIDTH / IN_PORT_DEPTH : default word width and FIFO depth
//   IB_IDLE  : value placed on IB while not enabled (all high-Z)
//   IB_EMPTY : value placed on IB while enabled with no data (all zero)
//   ptr_width() : read/write pointer width for a given depth
package in_port_pkg;

   localparam int unsigned IN_PORT_WIDTH = 4;
   localparam int unsigned IN_PORT_DEPTH = 4;

   // Bus constants are held wide and sliced down to WIDTH at the use site.
   localparam int unsigned IB_MAX_WIDTH = 64;
   localparam logic [IB_MAX_WIDTH-1:0] IB_IDLE  = {IB_MAX_WIDTH{1'bz}};
   localparam logic [IB_MAX_WIDTH-1:0] IB_EMPTY = '0;

   function automatic int unsigned ptr_width(input int unsigned depth);
      return (depth > 1) ? int'($clog2(depth)) : 1;
   endfunction

endpackage

// File: rtl/in_port_ram.sv
// DEPTH x WIDTH register array backing the input port FIFO.
//   clk   : write clock
//   we    : write enable, writes wdata to waddr on the rising edge
//   waddr : write address
//   wdata : write data
//   raddr : asynchronous read address
//   rdata : asynchronous read data
// The array has no reset; unused entries are masked by the buffer control.
module in_port_ram
   import in_port_pkg::*;
#(
   parameter int unsigned WIDTH = IN_PORT_WIDTH,
   parameter int unsigned DEPTH = IN_PORT_DEPTH,
   parameter int unsigned AW    = ptr_width(DEPTH)
) (
   input  logic             clk,
   input  logic             we,
   input  logic [AW-1:0]    waddr,
   input  logic [WIDTH-1:0] wdata,
   input  logic [AW-1:0]    raddr,
   output logic [WIDTH-1:0] rdata
);

   logic [WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/in_port_buffer.sv
// Input port buffer feeding the processor's internal bus.
// External words arrive through a valid/ready handshake and are queued in a
// DEPTH-entry FIFO; the head word is driven onto IB while EnableIn is high.
//   CLK, ResetN  : clock, synchronous active-low reset
//   DataIn, DataInValid, DataInReady : external write handshake
//   EnableIn     : drive IB from the head entry (IB high-Z when low)
//   PopIn        : consume the head entry (only while EnableIn is high)
//   IB           : tristate internal bus
//   Count, Empty, Full : occupancy status
//   Overflow, Underflow : sticky error flags, cleared by ClearFlags
module in_port_buffer
   import in_port_pkg::*;
#(
   parameter  int unsigned WIDTH = IN_PORT_WIDTH,
   parameter  int unsigned DEPTH = IN_PORT_DEPTH,
   localparam int unsigned CW    = $clog2(DEPTH + 1)
) (
   input  logic             CLK,
   input  logic             ResetN,
   input  logic [WIDTH-1:0] DataIn,
   input  logic             DataInValid,
   output logic             DataInReady,
   input  logic             EnableIn,
   input  logic             PopIn,
   output logic [WIDTH-1:0] IB,
   output logic [CW-1:0]    Count,
   output logic             Empty,
   output logic             Full,
   output logic             Overflow,
   output logic             Underflow,
   input  logic             ClearFlags
);

   localparam int unsigned AW = ptr_width(DEPTH);

   if ((DEPTH < 2) || (DEPTH > 16) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
      $error("in_port_buffer: DEPTH must be a power of two in 2..16");
   end

   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic             overflow_q, overflow_d;
   logic             underflow_q, underflow_d;

   logic             empty;
   logic             full;
   logic             push;
   logic             pop_req;
   logic             pop;
   logic [WIDTH-1:0] head;

   assign empty   = (count_q == '0);
   assign full    = (count_q == CW'(DEPTH));

   // Ready looks only at registered occupancy, so a pop on a full buffer
   // frees the slot for the following cycle, never the current one.
   assign DataInReady = ResetN & ~full;
   assign push        = DataInValid & DataInReady;
   assign pop_req     = EnableIn & PopIn;
   assign pop         = pop_req & ~empty;

   always_comb begin
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      count_d     = count_q;
      overflow_d  = overflow_q;
      underflow_d = underflow_q;

      if (push) begin
         wr_ptr_d = wr_ptr_q + AW'(1);
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + AW'(1);
      end

      unique case ({push, pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase

      // Clear first so a coincident set condition wins.
      if (ClearFlags) begin
         overflow_d  = 1'b0;
         underflow_d = 1'b0;
      end
      if (DataInValid && full) begin
         overflow_d = 1'b1;
      end
      if (pop_req && empty) begin
         underflow_d = 1'b1;
      end
   end

   always_ff @(posedge CLK) begin
      if (!ResetN) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         overflow_q  <= overflow_d;
         underflow_q <= underflow_d;
      end
   end

   in_port_ram #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_ram (
      .clk   (CLK),
      .we    (push),
      .waddr (wr_ptr_q),
      .wdata (DataIn),
      .raddr (rd_ptr_q),
      .rdata (head)
   );

   // Zeros while empty keep stale array contents off the bus.
   assign IB = !EnableIn ? IB_IDLE[WIDTH-1:0]
             : empty     ? IB_EMPTY[WIDTH-1:0]
             :             head;

   assign Count     = count_q;
   assign Empty     = empty;
   assign Full      = full;
   assign Overflow  = overflow_q;
   assign Underflow = underflow_q;

endmodule

// File: tb/tb_in_port_buffer.sv
// Self-checking bench for in_port_buffer: a 4x4 instance (A) for directed
// scenarios and an 8-bit x 16 instance (B) for wrap-around, both also driven
// with random traffic against queue-based reference models.
// While EnableIn is low the bench drives a known pattern onto each IB net;
// reading that pattern back shows the DUT has released the bus.
module tb_in_port_buffer;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int unsigned checks = 0;
   int unsigned passes = 0;

   // ---------------- instance A: WIDTH=4, DEPTH=4 ----------------
   logic       rstn_a = 1'b0, valid_a = 1'b0, en_a = 1'b0, pop_a = 1'b0, clr_a = 1'b0;
   logic [3:0] din_a = '0, pat_a = 4'h9;
   wire  [3:0] ib_a;
   logic       ready_a, empty_a, full_a, ovf_a, udf_a;
   logic [2:0] count_a;
   assign ib_a = en_a ? 4'bzzzz : pat_a;

   in_port_buffer #(.WIDTH(4), .DEPTH(4)) u_a (
      .CLK(clk), .ResetN(rstn_a), .DataIn(din_a), .DataInValid(valid_a),
      .DataInReady(ready_a), .EnableIn(en_a), .PopIn(pop_a), .IB(ib_a),
      .Count(count_a), .Empty(empty_a), .Full(full_a), .Overflow(ovf_a),
      .Underflow(udf_a), .ClearFlags(clr_a)
   );

   // ---------------- instance B: WIDTH=8, DEPTH=16 ----------------
   logic       rstn_b = 1'b0, valid_b = 1'b0, en_b = 1'b0, pop_b = 1'b0, clr_b = 1'b0;
   logic [7:0] din_b = '0, pat_b = 8'h5C;
   wire  [7:0] ib_b;
   logic       ready_b, empty_b, full_b, ovf_b, udf_b;
   logic [4:0] count_b;
   assign ib_b = en_b ? 8'hzz : pat_b;

   in_port_buffer #(.WIDTH(8), .DEPTH(16)) u_b (
      .CLK(clk), .ResetN(rstn_b), .DataIn(din_b), .DataInValid(valid_b),
      .DataInReady(ready_b), .EnableIn(en_b), .PopIn(pop_b), .IB(ib_b),
      .Count(count_b), .Empty(empty_b), .Full(full_b), .Overflow(ovf_b),
      .Underflow(udf_b), .ClearFlags(clr_b)
   );

   // ---------------- reference models ----------------
   logic [3:0] qa[$];
   logic [7:0] qb[$];
   bit ovfm_a = 0, udfm_a = 0, ovfm_b = 0, udfm_b = 0;

   function automatic void model_a();
      int unsigned n = qa.size();
      bit full = (n == 4);
      bit empty = (n == 0);
      if (!rstn_a) begin
         qa.delete(); ovfm_a = 0; udfm_a = 0;
         return;
      end
      if (clr_a) begin ovfm_a = 0; udfm_a = 0; end
      if (valid_a && full) ovfm_a = 1;
      if (en_a && pop_a && empty) udfm_a = 1;
      if (en_a && pop_a && !empty) void'(qa.pop_front());
      if (valid_a && !full) qa.push_back(din_a);
   endfunction

   function automatic void model_b();
      int unsigned n = qb.size();
      bit full = (n == 16);
      bit empty = (n == 0);
      if (!rstn_b) begin
         qb.delete(); ovfm_b = 0; udfm_b = 0;
         return;
      end
      if (clr_b) begin ovfm_b = 0; udfm_b = 0; end
      if (valid_b && full) ovfm_b = 1;
      if (en_b && pop_b && empty) udfm_b = 1;
      if (en_b && pop_b && !empty) void'(qb.pop_front());
      if (valid_b && !full) qb.push_back(din_b);
   endfunction

   function automatic logic [3:0] exp_ib_a();
      if (!en_a) return pat_a;
      if (qa.size() == 0) return 4'h0;
      return qa[0];
   endfunction

   function automatic logic [7:0] exp_ib_b();
      if (!en_b) return pat_b;
      if (qb.size() == 0) return 8'h00;
      return qb[0];
   endfunction

   // Advance one clock: models see the same inputs the DUTs sample.
   task automatic tick();
      @(posedge clk);
      model_a();
      model_b();
      #1;
   endtask

   task automatic idle_a();
      valid_a = 0; en_a = 0; pop_a = 0; clr_a = 0;
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      rstn_a = 0; rstn_b = 0;
      idle_a();
      #1;
      checks++; if (ready_a !== 1'b0) $display("FAIL reset_ready_low got=%b exp=0", ready_a); else passes++;
      tick(); tick();
      checks++; if (ready_a !== 1'b0) $display("FAIL reset_ready_held got=%b exp=0", ready_a); else passes++;
      checks++; if (empty_a !== 1'b1) $display("FAIL reset_empty got=%b exp=1", empty_a); else passes++;
      rstn_a = 1; rstn_b = 1;
      #1;
      checks++; if (ib_a !== pat_a) $display("FAIL reset_ib_released got=%h exp=%h", ib_a, pat_a); else passes++;
      checks++; if (count_a !== 3'd0) $display("FAIL reset_count got=%0d exp=0", count_a); else passes++;
      checks++; if (ready_a !== 1'b1) $display("FAIL reset_ready_after got=%b exp=1", ready_a); else passes++;
      checks++; if ({ovf_a, udf_a} !== 2'b00) $display("FAIL reset_flags got=%b exp=00", {ovf_a, udf_a}); else passes++;
      checks++; if ({empty_b, ready_b, count_b} !== {2'b11, 5'd0}) $display("FAIL reset_b_status got=%b exp=1100000", {empty_b, ready_b, count_b}); else passes++;
   endtask

   task automatic test_fifo_order();
      logic [3:0] seq [3] = '{4'h3, 4'hA, 4'h5};
      for (int i = 0; i < 3; i++) begin
         valid_a = 1; din_a = seq[i];
         tick();
         checks++; if (count_a !== 3'(i + 1)) $display("FAIL order_fill_count got=%0d exp=%0d", count_a, i + 1); else passes++;
      end
      valid_a = 0; en_a = 1; pop_a = 1;
      for (int i = 0; i < 3; i++) begin
         #1;
         checks++; if (ib_a !== seq[i]) $display("FAIL order_ib got=%h exp=%h", ib_a, seq[i]); else passes++;
         checks++; if (count_a !== 3'(3 - i)) $display("FAIL order_drain_count got=%0d exp=%0d", count_a, 3 - i); else passes++;
         tick();
      end
      checks++; if ({empty_a, count_a} !== 4'b1000) $display("FAIL order_end_empty got=%b exp=1000", {empty_a, count_a}); else passes++;
      checks++; if (ib_a !== 4'h0) $display("FAIL order_empty_ib got=%h exp=0", ib_a); else passes++;
      idle_a();
   endtask

   task automatic test_overflow();
      for (int v = 1; v <= 5; v++) begin
         valid_a = 1; din_a = 4'(v);
         tick();
         if (v == 4) begin
            checks++; if ({full_a, ready_a} !== 2'b10) $display("FAIL ovf_full got=%b exp=10", {full_a, ready_a}); else passes++;
            checks++; if (ovf_a !== 1'b0) $display("FAIL ovf_early got=%b exp=0", ovf_a); else passes++;
         end
      end
      valid_a = 0;
      #1;
      checks++; if ({ovf_a, ready_a, count_a} !== {2'b10, 3'd4}) $display("FAIL ovf_set got=%b exp=10100", {ovf_a, ready_a, count_a}); else passes++;
      en_a = 1; pop_a = 1;
      for (int i = 1; i <= 4; i++) begin
         #1;
         checks++; if (ib_a !== 4'(i)) $display("FAIL ovf_drain got=%h exp=%h", ib_a, 4'(i)); else passes++;
         tick();
      end
      idle_a(); clr_a = 1;
      tick();
      clr_a = 0;
      checks++; if (ovf_a !== 1'b0) $display("FAIL ovf_clear got=%b exp=0", ovf_a); else passes++;
   endtask

   task automatic test_full_push_pop();
      for (int v = 8; v < 12; v++) begin
         valid_a = 1; din_a = 4'(v);
         tick();
      end
      din_a = 4'hC; en_a = 1; pop_a = 1;
      #1;
      checks++; if (ib_a !== 4'h8) $display("FAIL fpp_head got=%h exp=8", ib_a); else passes++;
      tick();
      pop_a = 0; en_a = 0;
      #1;
      checks++; if ({count_a, ready_a} !== {3'd3, 1'b1}) $display("FAIL fpp_only_pop got=%b exp=0111", {count_a, ready_a}); else passes++;
      checks++; if (ovf_a !== ovfm_a) $display("FAIL fpp_ovf got=%b exp=%b", ovf_a, ovfm_a); else passes++;
      tick();
      valid_a = 0;
      checks++; if ({count_a, full_a} !== {3'd4, 1'b1}) $display("FAIL fpp_pending_accept got=%b exp=1001", {count_a, full_a}); else passes++;
      en_a = 1; pop_a = 1;
      for (int v = 9; v <= 12; v++) begin
         #1;
         checks++; if (ib_a !== 4'(v)) $display("FAIL fpp_drain got=%h exp=%h", ib_a, 4'(v)); else passes++;
         tick();
      end
      idle_a(); clr_a = 1;
      tick();
      clr_a = 0;
   endtask

   task automatic test_underflow();
      en_a = 1; pop_a = 1;
      #1;
      checks++; if (ib_a !== 4'h0) $display("FAIL udf_empty_ib got=%h exp=0", ib_a); else passes++;
      tick();
      checks++; if ({udf_a, count_a} !== 4'b1000) $display("FAIL udf_set got=%b exp=1000", {udf_a, count_a}); else passes++;
      pop_a = 0; clr_a = 1;
      tick();
      checks++; if (udf_a !== 1'b0) $display("FAIL udf_clear got=%b exp=0", udf_a); else passes++;
      pop_a = 1;
      tick();
      clr_a = 0;
      checks++; if (udf_a !== 1'b1) $display("FAIL udf_set_wins got=%b exp=1", udf_a); else passes++;
      valid_a = 1; din_a = 4'h6;
      #1;
      checks++; if (ib_a !== 4'h0) $display("FAIL udf_no_bypass got=%h exp=0", ib_a); else passes++;
      tick();
      valid_a = 0; pop_a = 0;
      #1;
      checks++; if ({ib_a, count_a} !== {4'h6, 3'd1}) $display("FAIL udf_push_only got=%h/%0d exp=6/1", ib_a, count_a); else passes++;
      pop_a = 1;
      tick();
      idle_a(); clr_a = 1;
      tick();
      clr_a = 0;
   endtask

   task automatic test_reset_mid();
      en_a = 1; pop_a = 1;
      tick();
      pop_a = 0; valid_a = 1;
      for (int v = 1; v <= 4; v++) begin
         din_a = 4'(v + 4);
         tick();
      end
      valid_a = 0; pop_a = 1;
      tick(); tick();
      checks++; if ({count_a, udf_a} !== {3'd2, 1'b1}) $display("FAIL rmid_pre got=%b exp=0101", {count_a, udf_a}); else passes++;
      rstn_a = 0; valid_a = 1; din_a = 4'hF;
      tick();
      rstn_a = 1; valid_a = 0; pop_a = 0;
      #1;
      checks++; if ({count_a, empty_a, ovf_a, udf_a} !== {3'd0, 3'b100}) $display("FAIL rmid_cleared got=%b exp=000100", {count_a, empty_a, ovf_a, udf_a}); else passes++;
      checks++; if (ib_a !== 4'h0) $display("FAIL rmid_ib got=%h exp=0", ib_a); else passes++;
      idle_a();
   endtask

   task automatic test_wrap_b();
      valid_b = 1;
      for (int i = 0; i < 5; i++) begin
         din_b = 8'($urandom);
         tick();
      end
      en_b = 1; pop_b = 1;
      for (int i = 0; i < 20; i++) begin
         din_b = 8'($urandom);
         #1;
         checks++; if (ib_b !== exp_ib_b()) $display("FAIL wrap_ib got=%h exp=%h", ib_b, exp_ib_b()); else passes++;
         checks++; if (count_b !== 5'd5) $display("FAIL wrap_count got=%0d exp=5", count_b); else passes++;
         tick();
      end
      valid_b = 0;
      for (int i = 0; i < 5; i++) begin
         #1;
         checks++; if (ib_b !== exp_ib_b()) $display("FAIL wrap_drain got=%h exp=%h", ib_b, exp_ib_b()); else passes++;
         tick();
      end
      checks++; if (empty_b !== 1'b1) $display("FAIL wrap_empty got=%b exp=1", empty_b); else passes++;
      en_b = 0; pop_b = 0;
   endtask

   task automatic test_random();
      for (int c = 0; c < 400; c++) begin
         rstn_a  = ($urandom_range(0, 59) != 0);
         valid_a = $urandom_range(0, 2) != 0;
         din_a   = 4'($urandom);
         en_a    = $urandom_range(0, 3) != 0;
         pop_a   = $urandom_range(0, 2) == 0;
         clr_a   = $urandom_range(0, 15) == 0;
         pat_a   = 4'($urandom);
         rstn_b  = ($urandom_range(0, 59) != 0);
         valid_b = $urandom_range(0, 1) != 0;
         din_b   = 8'($urandom);
         en_b    = $urandom_range(0, 3) != 0;
         pop_b   = $urandom_range(0, 2) == 0;
         clr_b   = $urandom_range(0, 15) == 0;
         pat_b   = 8'($urandom);
         #1;
         checks++;
         if ({ib_a, count_a, empty_a, full_a, ready_a, ovf_a, udf_a} !==
             {exp_ib_a(), 3'(qa.size()), qa.size() == 0, qa.size() == 4,
              rstn_a && qa.size() != 4, ovfm_a, udfm_a})
            $display("FAIL rand_a cyc=%0d got ib=%h cnt=%0d e=%b f=%b r=%b o=%b u=%b exp ib=%h cnt=%0d o=%b u=%b",
                     c, ib_a, count_a, empty_a, full_a, ready_a, ovf_a, udf_a,
                     exp_ib_a(), qa.size(), ovfm_a, udfm_a);
         else passes++;
         checks++;
         if ({ib_b, count_b, empty_b, full_b, ready_b, ovf_b, udf_b} !==
             {exp_ib_b(), 5'(qb.size()), qb.size() == 0, qb.size() == 16,
              rstn_b && qb.size() != 16, ovfm_b, udfm_b})
            $display("FAIL rand_b cyc=%0d got ib=%h cnt=%0d e=%b f=%b r=%b o=%b u=%b exp ib=%h cnt=%0d o=%b u=%b",
                     c, ib_b, count_b, empty_b, full_b, ready_b, ovf_b, udf_b,
                     exp_ib_b(), qb.size(), ovfm_b, udfm_b);
         else passes++;
         tick();
      end
   endtask

   initial begin
      test_reset();
      test_fifo_order();
      test_overflow();
      test_full_push_pop();
      test_underflow();
      test_reset_mid();
      test_wrap_b();
      test_random();
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
